// File: rtl/jedro_1_mem_pkg.sv
// ---------------------------------------------------------------------------
// jedro_1_mem_pkg
// Shared types for the jedro_1 instruction/data ROM path.
//   owner_e    : which master owns the read response due next cycle
//   mst_idx_e  : index of a master, used for the round-robin history
//   owner_from_gnt : maps a one-hot grant pair onto an owner code
// ---------------------------------------------------------------------------
package jedro_1_mem_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_M0   = 2'd1,
    OWNER_M1   = 2'd2
  } owner_e;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_idx_e;

  // Grant pair is one-hot or zero; anything else maps to NONE so a
  // corrupted grant never produces a response.
  function automatic owner_e owner_from_gnt(input logic [1:0] gnt);
    owner_e res;
    case (gnt)
      2'b01:   res = OWNER_M0;
      2'b10:   res = OWNER_M1;
      default: res = OWNER_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/jedro_1_rr_arb2.sv
// ---------------------------------------------------------------------------
// jedro_1_rr_arb2
// Purely combinational two-input round-robin selector.
//   i_req        [1:0] : request vector, bit 0 = master 0, bit 1 = master 1
//   i_last_grant       : master granted most recently
//   o_gnt        [1:0] : one-hot (or zero) grant vector
// On a conflict the master that was not granted last wins.
// ---------------------------------------------------------------------------
module jedro_1_rr_arb2
  import jedro_1_mem_pkg::*;
(
  input  logic [1:0] i_req,
  input  mst_idx_e   i_last_grant,
  output logic [1:0] o_gnt
);

  // Grant selection: single requester wins outright, conflicts alternate.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: begin
        if (i_last_grant == MST_M0) begin
          o_gnt = 2'b10;
        end else begin
          o_gnt = 2'b01;
        end
      end
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/jedro_1_rom_arbiter.sv
// ---------------------------------------------------------------------------
// jedro_1_rom_arbiter
// Shares one single-port ROM (read latency 1) between the fetch unit
// (master 0) and the load/store unit (master 1).
//   clk_i, rst_i              : clock, synchronous active-high reset
//   m0_req_i/addr_i/flush_i   : fetch request, address, jump flush
//   m0_gnt_o/rvalid_o/rdata_o : fetch grant (same cycle), response (t+1)
//   m1_req_i/addr_i           : load/store request, address
//   m1_gnt_o/rvalid_o/rdata_o : load/store grant, response
//   mem_ce_o/addr_o           : ROM read strobe and address
//   mem_rdata_i               : ROM data, valid the cycle after mem_ce_o
//   conflict_cnt_o            : saturating count of both-request cycles
// ---------------------------------------------------------------------------
module jedro_1_rom_arbiter
  import jedro_1_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_flush_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_ce_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  owner_e               r_owner;
  mst_idx_e             r_last_grant;
  logic [CNT_WIDTH-1:0] r_conflict_cnt;

  logic [1:0]           w_req;
  logic [1:0]           w_arb_gnt;
  logic [1:0]           w_gnt;
  logic                 w_conflict;
  owner_e               w_owner_nxt;
  logic                 w_m0_rvalid;
  logic                 w_m1_rvalid;

  assign w_req      = {m1_req_i, m0_req_i};
  assign w_conflict = m0_req_i & m1_req_i;

  jedro_1_rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_arb_gnt)
  );

  // Grants are suppressed while reset is held so no read is launched.
  always_comb begin
    w_gnt = 2'b00;
    if (rst_i) begin
      w_gnt = 2'b00;
    end else begin
      w_gnt = w_arb_gnt;
    end
  end

  assign m0_gnt_o = w_gnt[0];
  assign m1_gnt_o = w_gnt[1];
  assign mem_ce_o = w_gnt[0] | w_gnt[1];

  // ROM address mux: winner's address, zero when idle.
  always_comb begin
    mem_addr_o = {ADDR_WIDTH{1'b0}};
    if (w_gnt[0]) begin
      mem_addr_o = m0_addr_i;
    end else if (w_gnt[1]) begin
      mem_addr_o = m1_addr_i;
    end else begin
      mem_addr_o = {ADDR_WIDTH{1'b0}};
    end
  end

  assign w_owner_nxt = owner_from_gnt(w_gnt);

  // Owner, round-robin history and conflict counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner        <= OWNER_NONE;
      r_last_grant   <= MST_M1;
      r_conflict_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      r_owner <= w_owner_nxt;
      if (w_gnt[1]) begin
        r_last_grant <= MST_M1;
      end else if (w_gnt[0]) begin
        r_last_grant <= MST_M0;
      end
      if (w_conflict && (r_conflict_cnt != CNT_MAX)) begin
        r_conflict_cnt <= r_conflict_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Response routing. The owner register still holds a pre-reset grant
  // during the first reset cycle, so rst_i gates rvalid directly. A jump
  // flush kills only the fetch response arriving in the flush cycle.
  always_comb begin
    w_m0_rvalid = 1'b0;
    w_m1_rvalid = 1'b0;
    if (rst_i) begin
      w_m0_rvalid = 1'b0;
      w_m1_rvalid = 1'b0;
    end else begin
      w_m0_rvalid = (r_owner == OWNER_M0) && !m0_flush_i;
      w_m1_rvalid = (r_owner == OWNER_M1);
    end
  end

  assign m0_rvalid_o = w_m0_rvalid;
  assign m1_rvalid_o = w_m1_rvalid;

  // Data is zeroed whenever the matching valid is low.
  always_comb begin
    m0_rdata_o = {DATA_WIDTH{1'b0}};
    m1_rdata_o = {DATA_WIDTH{1'b0}};
    if (w_m0_rvalid) begin
      m0_rdata_o = mem_rdata_i;
    end else begin
      m0_rdata_o = {DATA_WIDTH{1'b0}};
    end
    if (w_m1_rvalid) begin
      m1_rdata_o = mem_rdata_i;
    end else begin
      m1_rdata_o = {DATA_WIDTH{1'b0}};
    end
  end

  assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_jedro_1_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jedro_1_rom_arbiter
// Directed bench: each step drives one cycle of inputs, checks the same-cycle
// grant against a small round-robin model, pops the response expected for
// this cycle from a scoreboard queue and pushes the response for the next.
// ---------------------------------------------------------------------------
module tb_jedro_1_rom_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_req_i;
  logic [AW-1:0] m0_addr_i;
  logic          m0_flush_i;
  logic          m0_gnt_o;
  logic          m0_rvalid_o;
  logic [DW-1:0] m0_rdata_o;
  logic          m1_req_i;
  logic [AW-1:0] m1_addr_i;
  logic          m1_gnt_o;
  logic          m1_rvalid_o;
  logic [DW-1:0] m1_rdata_o;
  logic          mem_ce_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_rdata_i;
  logic [CW-1:0] conflict_cnt_o;

  always #5 clk_i = ~clk_i;

  jedro_1_rom_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .m0_req_i       (m0_req_i),
    .m0_addr_i      (m0_addr_i),
    .m0_flush_i     (m0_flush_i),
    .m0_gnt_o       (m0_gnt_o),
    .m0_rvalid_o    (m0_rvalid_o),
    .m0_rdata_o     (m0_rdata_o),
    .m1_req_i       (m1_req_i),
    .m1_addr_i      (m1_addr_i),
    .m1_gnt_o       (m1_gnt_o),
    .m1_rvalid_o    (m1_rvalid_o),
    .m1_rdata_o     (m1_rdata_o),
    .mem_ce_o       (mem_ce_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rdata_i    (mem_rdata_i),
    .conflict_cnt_o (conflict_cnt_o)
  );

  // ROM contents: a scrambled function of the address.
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // ROM model: latency one, garbage on the bus when not read.
  logic          pend = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  always @(posedge clk_i) mem_rdata_i <= pend ? rom(pend_addr) : 32'hDEAD_BEEF;

  typedef struct packed {
    logic          vld;
    logic          mst;
    logic [AW-1:0] addr;
  } rsp_t;

  rsp_t          sbq[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  logic          m_last = 1'b1;
  logic [CW-1:0] m_cnt  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic q0, input logic [AW-1:0] a0,
                      input logic f, input logic q1, input logic [AW-1:0] a1);
    rsp_t          e;
    logic          g0;
    logic          g1;
    logic          rv0;
    logic          rv1;
    logic [AW-1:0] ea;
    @(negedge clk_i);
    rst_i = r; m0_req_i = q0; m0_addr_i = a0; m0_flush_i = f;
    m1_req_i = q1; m1_addr_i = a1;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (!r) begin
      if (q0 && q1) begin
        if (m_last) g0 = 1'b1; else g1 = 1'b1;
      end else begin
        g0 = q0; g1 = q1;
      end
    end
    ea = g0 ? a0 : (g1 ? a1 : '0);
    chk("m0_gnt", 64'(m0_gnt_o), 64'(g0));
    chk("m1_gnt", 64'(m1_gnt_o), 64'(g1));
    chk("mem_ce", 64'(mem_ce_o), 64'(g0 | g1));
    chk("mem_addr", 64'(mem_addr_o), 64'(ea));
    if (sbq.size() > 0) e = sbq.pop_front(); else e = '0;
    rv0 = e.vld && !e.mst && !f && !r;
    rv1 = e.vld && e.mst && !r;
    chk("m0_rvalid", 64'(m0_rvalid_o), 64'(rv0));
    chk("m0_rdata", 64'(m0_rdata_o), 64'(rv0 ? rom(e.addr) : 32'h0));
    chk("m1_rvalid", 64'(m1_rvalid_o), 64'(rv1));
    chk("m1_rdata", 64'(m1_rdata_o), 64'(rv1 ? rom(e.addr) : 32'h0));
    chk("conflict_cnt", 64'(conflict_cnt_o), 64'(m_cnt));
    e.vld = g0 | g1; e.mst = g1; e.addr = ea;
    sbq.push_back(e);
    pend = g0 | g1; pend_addr = ea;
    if (r) begin
      m_last = 1'b1; m_cnt = '0;
    end else begin
      if (g0 | g1) m_last = g1;
      if (q0 && q1 && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    end
  endtask

  initial begin
    int guard;
    rst_i = 1'b1; m0_req_i = 1'b0; m0_addr_i = '0; m0_flush_i = 1'b0;
    m1_req_i = 1'b0; m1_addr_i = '0;

    // Reset with both masters requesting: nothing granted, nothing valid.
    step(1, 1, 32'h10, 0, 1, 32'h40);
    step(1, 1, 32'h10, 0, 1, 32'h40);
    chk("rst_cnt_zero", 64'(conflict_cnt_o), 64'h0);

    // Master 0 alone, three back-to-back reads of 0x10.
    step(0, 1, 32'h10, 0, 0, 32'h0);
    step(0, 1, 32'h10, 0, 0, 32'h0);
    step(0, 1, 32'h10, 0, 0, 32'h0);
    chk("m0_stream_data", 64'(m0_rdata_o), 64'(rom(32'h10)));
    step(0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 32'h0);

    // Master 1 alone, then alternating singles.
    step(0, 0, 32'h0, 0, 1, 32'h44);
    step(0, 1, 32'h14, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h48);
    step(0, 0, 32'h0, 0, 0, 32'h0);

    // Conflict from reset: M0 first, then alternating.
    step(1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, 32'h20, 0, 1, 32'h40);
    chk("conflict_first_m0", 64'(m0_gnt_o), 64'h1);
    step(0, 1, 32'h20, 0, 1, 32'h40);
    chk("conflict_second_m1", 64'(m1_gnt_o), 64'h1);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h20, 0, 1, 32'h40);
    step(0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 32'h0);

    // Flush kills the pending fetch response, new fetch proceeds.
    step(0, 1, 32'h08, 0, 0, 32'h0);
    step(0, 1, 32'h80, 1, 0, 32'h0);
    chk("flush_kills_rvalid", 64'(m0_rvalid_o), 64'h0);
    step(0, 0, 32'h0, 0, 0, 32'h0);
    chk("post_flush_data", 64'(m0_rdata_o), 64'(rom(32'h80)));

    // Flush in a cycle with nothing pending for m0 must not touch m1.
    step(0, 0, 32'h0, 0, 1, 32'h50);
    step(0, 0, 32'h0, 1, 0, 32'h0);

    // Reset right after an m1 grant: response dropped, M0 wins afterwards.
    step(0, 0, 32'h0, 0, 1, 32'h60);
    step(1, 1, 32'h24, 0, 1, 32'h64);
    chk("rst_kills_m1", 64'(m1_rvalid_o), 64'h0);
    step(0, 1, 32'h24, 0, 1, 32'h64);
    chk("post_rst_m0_wins", 64'(m0_gnt_o), 64'h1);
    step(0, 0, 32'h0, 0, 0, 32'h0);

    // Saturation: hold both requests until the counter is one below max.
    guard = 0;
    while ((m_cnt != 16'hFFFE) && (guard < 70000)) begin
      step(0, 1, 32'h20, 0, 1, 32'h40);
      guard++;
    end
    chk("sat_reach_guard", 64'(guard < 70000), 64'h1);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h20, 0, 1, 32'h40);
    step(0, 0, 32'h0, 0, 0, 32'h0);
    chk("cnt_saturated", 64'(conflict_cnt_o), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
